// File: rtl/bkm_video_pkg.sv
// Shared types and constants for the analogue video path sequencer.
package bkm_video_pkg;

  // Sequencer states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    NOSIG   = 2'd0,
    MUTE    = 2'd1,
    ACQUIRE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  // Lowest format code treated as HD when deciding Y/G normalisation.
  localparam logic [7:0] FMT_HD_MIN = 8'h06;

  // Y/G normalise enable: RGB follows the sync-source select, component
  // follows the SD/HD split of the detected format; both are active-low sources.
  function automatic logic calc_norm_y_g(input logic       rgb_comp,
                                         input logic       int_ext,
                                         input logic [7:0] fmt);
    return ~(rgb_comp ? int_ext : (fmt >= FMT_HD_MIN));
  endfunction

endpackage

// File: rtl/sync_edge_detector.sv
// Two-flop synchroniser for an asynchronous level, followed by a registered
// one-clock pulse on each falling edge of the synchronised level.
module sync_edge_detector #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;
  logic r_fall;

  // Synchronise the pin, keep one cycle of history and register the falling-edge pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta   <= RESET_LEVEL;
      r_sync   <= RESET_LEVEL;
      r_sync_d <= RESET_LEVEL;
      r_fall   <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      r_fall   <= r_sync_d & ~r_sync;
    end
  end

  assign o_fall = r_fall;

endmodule

// File: rtl/video_path_sequencer.sv
// Sequences the analogue video path through signal loss, re-acquisition and
// steady display: mutes while anything is unsettled, unmutes only after the
// format has been stable for STABLE_FRAMES vsyncs.
module video_path_sequencer
  import bkm_video_pkg::*;
#(
  parameter int MUTE_CYCLES   = 50000,
  parameter int STABLE_FRAMES = 4,
  parameter int VS_TIMEOUT    = 5000000
) (
  input  logic       clk_50mhz_in,
  input  logic       reset_x,
  input  logic       signal_present,
  input  logic       vsync_in_x,
  input  logic [7:0] video_format,
  input  logic       rgb_comp_x,
  input  logic       int_ext_x,
  input  logic       host_req,
  output logic       host_ack,
  output logic       video_mute,
  output logic       locked,
  output logic [7:0] format_latched,
  output logic       norm_y_g
);

  localparam int MW = $clog2(MUTE_CYCLES + 1);
  localparam int FW = $clog2(STABLE_FRAMES + 1);
  localparam int WW = $clog2(VS_TIMEOUT + 1);
  localparam logic [MW-1:0] MUTE_LOAD  = MW'(MUTE_CYCLES - 1);
  localparam logic [FW-1:0] FRAMES_MAX = FW'(STABLE_FRAMES);
  localparam logic [WW-1:0] WD_LAST    = WW'(VS_TIMEOUT - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [MW-1:0]   r_mute_cnt;
  logic [FW-1:0]   r_frame_cnt;
  logic [FW-1:0]   w_frame_inc;
  logic [FW-1:0]   w_frame_seen;
  logic [7:0]      r_candidate;
  logic [WW-1:0]   r_wd_cnt;
  logic [7:0]      r_format_latched;
  logic            r_norm_y_g;
  logic            r_host_ack;
  logic            r_req_armed;
  logic            r_rgb_d;
  logic            r_int_d;
  logic            r_video_mute;
  logic            r_locked;
  logic            w_vs_edge;
  logic            w_accept;
  logic            w_wd_fire;
  logic            w_lock_hit;
  logic            w_cfg_change;

  sync_edge_detector #(.RESET_LEVEL(1'b1)) u_vs_edge (
    .i_clk   (clk_50mhz_in),
    .i_rst_n (reset_x),
    .i_async (vsync_in_x),
    .o_fall  (w_vs_edge)
  );

  // A request is taken once per high phase of host_req, and never while the signal is lost.
  assign w_accept     = signal_present & host_req & r_req_armed;
  // A vsync arriving in the same cycle means the timeout did not really expire.
  assign w_wd_fire    = (r_wd_cnt == WD_LAST) && !w_vs_edge;
  assign w_cfg_change = (rgb_comp_x != r_rgb_d) || (int_ext_x != r_int_d);
  assign w_lock_hit   = (r_state == ACQUIRE) && w_vs_edge && (w_frame_seen == FRAMES_MAX);

  // Frame count this vsync would produce: extend a matching run or restart at one.
  always_comb begin
    w_frame_inc  = (r_frame_cnt == FRAMES_MAX) ? FRAMES_MAX : r_frame_cnt + 1'b1;
    w_frame_seen = (video_format == r_candidate) ? w_frame_inc : FW'(1);
  end

  // Next-state: signal loss beats host request, which beats the state-local rules.
  always_comb begin
    w_state_next = r_state;
    if (!signal_present) begin
      w_state_next = NOSIG;
    end else if (w_accept) begin
      w_state_next = MUTE;
    end else begin
      case (r_state)
        NOSIG:   w_state_next = MUTE;
        MUTE:    if (r_mute_cnt == '0) w_state_next = ACQUIRE;
        ACQUIRE: if (w_lock_hit) w_state_next = LOCKED;
        LOCKED:  if ((w_vs_edge && (video_format != r_format_latched)) ||
                     w_wd_fire || w_cfg_change) w_state_next = MUTE;
        default: w_state_next = NOSIG;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) r_state <= NOSIG;
    else          r_state <= w_state_next;
  end

  // Mute hold counter: reloaded on every entry into MUTE (including a host re-entry), stops at zero.
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      r_mute_cnt <= '0;
    end else if ((w_state_next == MUTE) && ((r_state != MUTE) || w_accept)) begin
      r_mute_cnt <= MUTE_LOAD;
    end else if ((r_state == MUTE) && (r_mute_cnt != '0)) begin
      r_mute_cnt <= r_mute_cnt - 1'b1;
    end
  end

  // Format stability tracking; held cleared outside ACQUIRE so every acquisition starts fresh.
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      r_frame_cnt <= '0;
      r_candidate <= 8'h00;
    end else if (r_state != ACQUIRE) begin
      r_frame_cnt <= '0;
      r_candidate <= 8'h00;
    end else if (w_vs_edge) begin
      r_frame_cnt <= w_frame_seen;
      r_candidate <= video_format;
    end else if (w_wd_fire) begin
      r_frame_cnt <= '0;
    end
  end

  // Latch the format only when the lock actually happens; a simultaneous signal loss blocks it.
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x)
      r_format_latched <= 8'h00;
    else if (w_lock_hit && (w_state_next == LOCKED))
      r_format_latched <= video_format;
  end

  // Vsync watchdog: restarts on vsync, on any state change and after firing, so it never wraps.
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x)
      r_wd_cnt <= '0;
    else if (w_vs_edge || (w_state_next != r_state) || w_wd_fire)
      r_wd_cnt <= '0;
    else
      r_wd_cnt <= r_wd_cnt + 1'b1;
  end

  // Host handshake: one ack per accepted request, re-armed once host_req has been seen low.
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      r_host_ack  <= 1'b0;
      r_req_armed <= 1'b1;
    end else begin
      r_host_ack <= w_accept;
      if (w_accept)      r_req_armed <= 1'b0;
      else if (!host_req) r_req_armed <= 1'b1;
    end
  end

  // Registered outputs and config history; normalise only moves while the path is muted.
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      r_video_mute <= 1'b1;
      r_locked     <= 1'b0;
      r_norm_y_g   <= 1'b0;
      r_rgb_d      <= 1'b0;
      r_int_d      <= 1'b0;
    end else begin
      r_video_mute <= (r_state != LOCKED);
      r_locked     <= (r_state == LOCKED);
      r_rgb_d      <= rgb_comp_x;
      r_int_d      <= int_ext_x;
      if (r_state == MUTE)
        r_norm_y_g <= calc_norm_y_g(rgb_comp_x, int_ext_x, video_format);
    end
  end

  assign host_ack       = r_host_ack;
  assign video_mute     = r_video_mute;
  assign locked         = r_locked;
  assign format_latched = r_format_latched;
  assign norm_y_g       = r_norm_y_g;

endmodule

// File: tb/tb_video_path_sequencer.sv
// Directed bench for video_path_sequencer with short mute/timeout parameters.
module tb_video_path_sequencer;
  import bkm_video_pkg::*;

  logic       clk = 1'b0;
  logic       reset_x;
  logic       signal_present;
  logic       vsync_in_x;
  logic [7:0] video_format;
  logic       rgb_comp_x;
  logic       int_ext_x;
  logic       host_req;
  logic       host_ack;
  logic       video_mute;
  logic       locked;
  logic [7:0] format_latched;
  logic       norm_y_g;

  int vectors     = 0;
  int miscompares = 0;

  video_path_sequencer #(
    .MUTE_CYCLES   (10),
    .STABLE_FRAMES (4),
    .VS_TIMEOUT    (1000)
  ) dut (
    .clk_50mhz_in   (clk),
    .reset_x        (reset_x),
    .signal_present (signal_present),
    .vsync_in_x     (vsync_in_x),
    .video_format   (video_format),
    .rgb_comp_x     (rgb_comp_x),
    .int_ext_x      (int_ext_x),
    .host_req       (host_req),
    .host_ack       (host_ack),
    .video_mute     (video_mute),
    .locked         (locked),
    .format_latched (format_latched),
    .norm_y_g       (norm_y_g)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input state_t s, input string tag);
    int n = 0;
    while ((dut.r_state != s) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    chk(tag, dut.r_state, s);
  endtask

  // Pin low for two clocks starting at the current negedge; returns two negedges later.
  task automatic vs_pulse(input logic [7:0] fmt);
    video_format = fmt;
    vsync_in_x   = 1'b0;
    tick(2);
    vsync_in_x   = 1'b1;
  endtask

  task automatic vs_frame(input logic [7:0] fmt);
    vs_pulse(fmt);
    tick(9);
  endtask

  initial begin
    int cnt;
    int acks;
    int entries;
    state_t prev;

    reset_x = 1'b0; signal_present = 1'b0; vsync_in_x = 1'b1;
    video_format = 8'h03; rgb_comp_x = 1'b0; int_ext_x = 1'b0; host_req = 1'b0;
    tick(3);
    chk("rst_mute", video_mute, 1'b1);
    chk("rst_locked", locked, 1'b0);
    chk("rst_fmt", format_latched, 8'h00);
    chk("rst_norm", norm_y_g, 1'b0);
    chk("rst_ack", host_ack, 1'b0);
    chk("rst_state", dut.r_state, NOSIG);

    // Power-up acquisition on format 03; MUTE must last exactly 10 clocks.
    reset_x = 1'b1; signal_present = 1'b1;
    tick(1);
    cnt = 0;
    while ((dut.r_state == MUTE) && (cnt < 50)) begin
      cnt++;
      tick(1);
    end
    chk("mute_len", cnt, 10);
    chk("acq_after_mute", dut.r_state, ACQUIRE);
    chk("norm_fmt03", norm_y_g, 1'b1);
    vs_frame(8'h03); vs_frame(8'h03); vs_frame(8'h03);
    vs_pulse(8'h03);
    tick(2);
    chk("state_locked_n4", dut.r_state, LOCKED);
    chk("locked_n4", locked, 1'b0);
    tick(1);
    chk("locked_n5", locked, 1'b1);
    chk("unmute_n5", video_mute, 1'b0);
    chk("latched_03", format_latched, 8'h03);

    // Format change while locked: mute one clock after the state leaves LOCKED.
    tick(5);
    vs_pulse(8'h05);
    tick(2);
    chk("fmtchg_state", dut.r_state, MUTE);
    chk("fmtchg_mute_n4", video_mute, 1'b0);
    tick(1);
    chk("fmtchg_mute_n5", video_mute, 1'b1);
    wait_state(ACQUIRE, "fmtchg_acq");
    chk("norm_fmt05", norm_y_g, 1'b1);
    vs_frame(8'h05); vs_frame(8'h05); vs_frame(8'h05); vs_frame(8'h05);
    chk("relock_05", locked, 1'b1);
    chk("latched_05", format_latched, 8'h05);

    // Candidate restart: 03,03 then 07 x4, normalise computed from 07 during mute.
    vs_frame(8'h07);
    wait_state(ACQUIRE, "to_acq_07");
    chk("norm_fmt07", norm_y_g, 1'b0);
    vs_frame(8'h03); vs_frame(8'h03);
    chk("frame_two_03", dut.r_frame_cnt, 2);
    vs_pulse(8'h07);
    tick(2);
    chk("frame_restart", dut.r_frame_cnt, 1);
    chk("cand_07", dut.r_candidate, 8'h07);
    tick(7);
    vs_frame(8'h07); vs_frame(8'h07);
    chk("not_locked_3x07", dut.r_state, ACQUIRE);
    vs_pulse(8'h07);
    tick(2);
    chk("lock07_state", dut.r_state, LOCKED);
    tick(1);
    chk("lock07_locked", locked, 1'b1);
    chk("latched_07", format_latched, 8'h07);
    chk("norm_07_locked", norm_y_g, 1'b0);

    // Vsync stops: watchdog reaches 999 after the lock edge, MUTE at N1004, mute at N1005.
    tick(999);
    chk("wd_state_n1004", dut.r_state, MUTE);
    chk("wd_mute_n1004", video_mute, 1'b0);
    tick(1);
    chk("wd_mute_n1005", video_mute, 1'b1);
    tick(8);
    chk("wd_still_mute", dut.r_state, MUTE);
    tick(1);
    chk("wd_acq", dut.r_state, ACQUIRE);

    // Held host request: one ack, one MUTE entry.
    vs_frame(8'h07); vs_frame(8'h07); vs_frame(8'h07); vs_frame(8'h07);
    chk("host_pre_locked", locked, 1'b1);
    host_req = 1'b1;
    acks = 0; entries = 0; prev = dut.r_state;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (host_ack) acks++;
      if ((dut.r_state == MUTE) && (prev != MUTE)) entries++;
      prev = dut.r_state;
    end
    chk("host_acks", acks, 1);
    chk("host_mute_entries", entries, 1);
    host_req = 1'b0;
    tick(2);

    // Request coinciding with signal loss: NOSIG, no ack.
    host_req = 1'b1; signal_present = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (host_ack) acks++;
    end
    chk("loss_req_acks", acks, 0);
    chk("loss_req_state", dut.r_state, NOSIG);
    host_req = 1'b0;

    // Lock and signal loss in the same cycle: NOSIG wins, latched format kept.
    signal_present = 1'b1;
    tick(1);
    wait_state(ACQUIRE, "simul_acq");
    vs_frame(8'h05); vs_frame(8'h05); vs_frame(8'h05);
    vs_pulse(8'h05);
    tick(1);
    signal_present = 1'b0;
    tick(1);
    chk("simul_state", dut.r_state, NOSIG);
    chk("simul_latched", format_latched, 8'h07);
    tick(1);
    chk("simul_locked", locked, 1'b0);

    // Asynchronous reset in ACQUIRE with three matching frames counted.
    rgb_comp_x = 1'b1; int_ext_x = 1'b0; video_format = 8'h03;
    signal_present = 1'b1;
    tick(1);
    wait_state(ACQUIRE, "rst_test_acq");
    vs_frame(8'h03); vs_frame(8'h03); vs_frame(8'h03);
    chk("pre_rst_frames", dut.r_frame_cnt, 3);
    chk("pre_rst_norm", norm_y_g, 1'b1);
    #1 reset_x = 1'b0;
    #1;
    chk("arst_fmt", format_latched, 8'h00);
    chk("arst_norm", norm_y_g, 1'b0);
    chk("arst_mute", video_mute, 1'b1);
    chk("arst_locked", locked, 1'b0);
    chk("arst_ack", host_ack, 1'b0);
    chk("arst_state", dut.r_state, NOSIG);
    chk("arst_frames", dut.r_frame_cnt, 0);
    tick(2);
    reset_x = 1'b1;
    tick(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
